// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline hazard controller bus: stage status in, latch controls and counters out
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             dREN_m;
  logic             dWEN_m;
  logic [1:0]       pcSrc_m;
  logic             halt_m;
  logic             dREN_x;
  logic [4:0]       rd_x;
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, dREN_m, dWEN_m, pcSrc_m, halt_m, dREN_x, rd_x, rs1_d, rs2_d,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dREN_m, dWEN_m, pcSrc_m, halt_m, dREN_x, rd_x, rs1_d, rs2_d,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - per-latch enable/flush sequencer with data-wait watchdog and perf counters
module pipe_hazard_ctrl #(
  parameter int DWAIT_MAX = 255,
  parameter int CNT_W     = 32
) (
  input logic              CLK,
  input logic              nRST,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DWAIT  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam int WCNT_W = $clog2(DWAIT_MAX + 2);
  localparam logic [WCNT_W-1:0] WAIT_SAT = WCNT_W'(DWAIT_MAX + 1);

  logic [1:0]        state, next_state;
  logic [WCNT_W-1:0] wcnt;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_q, flush_q;

  // latch vectors ordered {ifid, idex, exmem, memwb}
  logic       pc_en_c;
  logic [3:0] en_c, fl_c;
  logic       flush_evt;
  logic       memop, luse, mem_wait;

  assign memop    = hz.dREN_m | hz.dWEN_m;
  assign mem_wait = memop & ~hz.dhit;
  assign luse     = hz.dREN_x & (hz.rd_x != 5'd0) &
                    ((hz.rd_x == hz.rs1_d) | (hz.rd_x == hz.rs2_d));

  always_comb begin
    pc_en_c    = 1'b0;
    en_c       = 4'b0000;
    fl_c       = 4'b0000;
    flush_evt  = 1'b0;
    next_state = state;
    if (state != HALTED) begin
      next_state = RUN;
      if (hz.halt_m) begin
        en_c       = 4'b0001;
        fl_c       = 4'b1110;
        next_state = HALTED;
      end else if (mem_wait) begin
        fl_c       = 4'b0001;
        next_state = DWAIT;
      end else if (hz.pcSrc_m != 2'd0) begin
        pc_en_c   = 1'b1;
        en_c      = 4'b0001;
        fl_c      = 4'b1110;
        flush_evt = 1'b1;
      end else if (luse) begin
        en_c = 4'b0011;
        fl_c = 4'b0100;
      end else if (!hz.ihit) begin
        en_c = 4'b0111;
        fl_c = 4'b1000;
      end else begin
        pc_en_c = 1'b1;
        en_c    = 4'b1111;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      wcnt      <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state <= next_state;
      if (next_state == DWAIT) begin
        if (state != DWAIT)
          wcnt <= WCNT_W'(1);
        else if (wcnt != WAIT_SAT)
          wcnt <= wcnt + 1'b1;
      end else begin
        wcnt <= '0;
      end
      if (wcnt == WAIT_SAT)
        timeout_q <= 1'b1;
      if (!pc_en_c && state != HALTED)
        stall_q <= stall_q + 1'b1;
      if (flush_evt)
        flush_q <= flush_q + 1'b1;
    end
  end

  // gated by nRST so no enable can leak out while reset is held
  assign hz.pc_en       = nRST & pc_en_c;
  assign hz.ifid_en     = nRST & en_c[3];
  assign hz.ifid_flush  = nRST & fl_c[3];
  assign hz.idex_en     = nRST & en_c[2];
  assign hz.idex_flush  = nRST & fl_c[2];
  assign hz.exmem_en    = nRST & en_c[1];
  assign hz.exmem_flush = nRST & fl_c[1];
  assign hz.memwb_en    = nRST & en_c[0];
  assign hz.memwb_flush = nRST & fl_c[0];

  assign hz.halt        = (state == HALTED);
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of one core. Each cycle it generates the per-latch enable/flush pair and the PC enable from cache handshakes, load-use hazards, resolved control transfers and halt. A small FSM (RUN/DWAIT/HALTED) tracks data-memory waits and halt. It also keeps a memory-wait watchdog and performance counters.

Parameters:
DWAIT_MAX, 255, data-wait cycles tolerated before mem_timeout asserts
CNT_W, 32, width of the performance counters

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_m  in  1  load in MEM stage (EX/MEM output)
dWEN_m  in  1  store in MEM stage
pcSrc_m  in  2  control transfer in MEM; nonzero means redirect
halt_m  in  1  halt instruction in MEM
dREN_x  in  1  load in EX stage (ID/EX output)
rd_x  in  5  destination reg in EX
rs1_d  in  5  source reg 1 in ID (IF/ID output)
rs2_d  in  5  source reg 2 in ID
pc_en  out  1  PC update enable
ifid_en, ifid_flush  out  1 each  IF/ID controls
idex_en, idex_flush  out  1 each  ID/EX controls
exmem_en, exmem_flush  out  1 each  EX/MEM controls
memwb_en, memwb_flush  out  1 each  MEM/WB controls
halt  out  1  core halted (sticky)
mem_timeout  out  1  watchdog error (sticky)
stall_cnt  out  CNT_W  cycles with pc_en=0 while not HALTED
flush_cnt  out  CNT_W  control-transfer flush events

Behaviour:
- Reset: state=RUN; halt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0, wait counter=0. Control outputs are combinational from state and inputs; they must not glitch to enables during reset. While nRST=0, all *_en=0 and all *_flush=0.
- Invariant: a latch never sees en=1 and flush=1 in the same cycle. Flush is only asserted with en=0.
- memop = dREN_m | dWEN_m. luse = dREN_x & (rd_x!=0) & (rd_x==rs1_d | rd_x==rs2_d).
- RUN and DWAIT use the same decision. The first matching rule wins:
  1. halt_m: memwb_en=1. ifid/idex/exmem flush=1. pc_en=0. Next state HALTED.
  2. memop & !dhit: all en=0, memwb_flush=1 (bubble into WB). Next state DWAIT.
  3. pcSrc_m!=0: pc_en=1, memwb_en=1. ifid/idex/exmem flush=1. flush_cnt++. Next state RUN.
  4. luse: pc_en=0, ifid_en=0, ifid_flush=0 (hold). idex_flush=1. exmem_en=1, memwb_en=1. Next state RUN.
  5. !ihit: pc_en=0, ifid_flush=1. idex/exmem/memwb en=1. Next state RUN.
  6. else: all en=1. Next state RUN.
- luse and !ihit together: luse wins; IF/ID holds.
- DWAIT: each cycle with memop & !dhit increments the wait counter, saturating at DWAIT_MAX+1. When the counter exceeds DWAIT_MAX, mem_timeout is set on the next edge and stays set until reset. Leaving DWAIT clears the counter. The pipeline keeps waiting; the timeout does not abort the access.
- Entering DWAIT from RUN loads the wait counter with 1.
- HALTED: absorbing state. All en=0, all flush=0, pc_en=0. halt=1 from the first edge in HALTED, so halt rises exactly 1 cycle after halt_m is sampled. Only nRST exits HALTED.
- stall_cnt increments on every edge where pc_en=0 and state!=HALTED. Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-DWAIT or HALTED returns everything to reset values asynchronously.

Test Plan:
- Reset then ihit=1, no hazards for 5 cycles -> all en=1, all flush=0, stall_cnt=0, state RUN.
- Load in EX with rd_x=5, rs2_d=5 -> that cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt=1. Repeat with rd_x=0 -> no stall.
- dREN_m=1, dhit held low 3 cycles then high -> 3 cycles of all en=0 with memwb_flush=1 and state DWAIT, then normal advance; stall_cnt=3, mem_timeout=0.
- DWAIT_MAX=4, dhit low 6 cycles -> mem_timeout=1 after wait counter reaches 5, remains 1 after dhit; cleared only by nRST.
- pcSrc_m=2 with ihit=0 and luse=1 simultaneously -> branch rule wins: pc_en=1, ifid/idex/exmem flush=1, memwb_en=1, flush_cnt=1.
- halt_m=1 -> memwb_en=1, upstream flushes; next cycle halt=1 and all controls 0 for 10 cycles; assert nRST=0 -> halt=0 immediately.
